tx_fifo_rd_ctrl: RTL and testbench
==================================

Name: tx_fifo_rd_ctrl

Overview:
- Read-side controller for the TX clock-domain-crossing FIFO (72-bit XGMII words, read side on rclk).
- Pops words when the downstream 64b/66b encoder is ready and re-registers them as txd/txc.
- Substitutes Idle on FIFO underrun between frames.
- On underrun mid-frame: emits an Error column, aborts the frame, and discards the remainder up to its Terminate.

Parameters:
- DSIZE, 72, FIFO word width; rdata[71:64]=txc, rdata[63:0]=txd; lane i = txd[8i+7:8i], txc[i].
- CNT_W, 16, width of the saturating underrun counter.
- LANE4_START, 1, when 1 a Start in lane 4 is also recognised.

Ports:
- rclk  in  1  read-domain clock (FIFO read clock, encoder clock).
- rrst  in  1  asynchronous active-high reset.
- rempty  in  1  FIFO empty flag.
- rdata  in  DSIZE  FIFO head word; valid whenever rempty=0 (combinational memory read).
- rinc  out  1  FIFO pop strobe.
- enc_ready  in  1  encoder accepts a column this cycle (low during gearbox pause).
- txd  out  64  registered XGMII data to the encoder.
- txc  out  8  registered XGMII control to the encoder.
- tx_valid  out  1  txd/txc updated this cycle.
- in_frame  out  1  state is FRAME.
- underrun  out  1  one-cycle pulse on a mid-frame underrun.
- underrun_cnt  out  CNT_W  saturating count of underrun events.

Behaviour:
- Reset (async assert, released on rclk):
  - state=IDLE, rinc=0, txd=64'h0707070707070707, txc=8'hFF.
  - tx_valid=0, underrun=0, underrun_cnt=0.
- rinc is combinational: rinc = enc_ready & ~rempty. rinc is never 1 while rempty=1.
- Output registers load only when enc_ready=1. tx_valid is enc_ready registered: 1-cycle latency from the pop to txd/txc.
- enc_ready=0: no pop, txd/txc hold their values, tx_valid=0 next cycle.
- Column decode, on rdata:
  - start: txc[0] & lane0==FB, or (LANE4_START & txc[4] & lane4==FB).
  - term: any i with txc[i] & lane_i==FD.
- States: IDLE, FRAME, ABORT. All actions below apply only when enc_ready=1.
- IDLE:
  - rempty=1: output the Idle column.
  - Otherwise pass rdata through.
  - start & ~term -> FRAME.
  - Any other column stays IDLE (ordered sets and idles pass through).
- FRAME:
  - rempty=0: pass rdata through.
    - term with no lane-4 start -> IDLE.
    - term with lane-4 start after it -> stay FRAME (back-to-back frames).
  - rempty=1: output Error column txd=64'hFEFEFEFEFEFEFEFE, txc=8'hFF.
    - underrun pulses for 1 cycle; underrun_cnt increments, saturating at all-ones.
    - -> ABORT.
- ABORT:
  - Output the Idle column every ready cycle.
  - Pop (discard) available words until a column with term is popped.
  - If that column also holds a lane-4 start -> FRAME.
  - Otherwise -> IDLE.
  - rempty=1 in ABORT: stay, emit Idle, no extra count.
- A start seen while in FRAME without a preceding term is treated as a data column (no resync). The encoder flags it.
- Async reset asserted mid-frame: immediate return to the reset values. The FIFO is reset by the same domain reset.

Decomposition:
- Package pcs_xgmii_pkg:
  - Constants XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE.
  - IDLE_COL and ERROR_COL 72-bit words.
  - State encoding IDLE/FRAME/ABORT.
- One combinational sub-module xgmii_ctrl_decode: 72-bit column in; start, start_lane4, term out.
- The FSM, output registers and counter stay in tx_fifo_rd_ctrl.

Test Plan:
- Reset, rempty=1, enc_ready=1 for 10 cycles -> rinc=0, txd=0707..07, txc=FF, tx_valid=1 from cycle 2, underrun_cnt=0.
- Push frame: start (txc=01, lane0=FB), 6 data columns, term column (txc=F0, lane4=FD) -> 8 pops, txd/txc match one cycle later, in_frame high for 7 cycles, then IDLE.
- Hold enc_ready=0 for 1 cycle every 33 cycles during a frame -> no pop on those cycles, txd held, tx_valid=0, no data lost or duplicated.
- Starve the FIFO after 3 frame columns -> Error column FEFE..FE/FF out, underrun=1 for 1 cycle, underrun_cnt=1. Remaining 4 columns popped with Idle output; IDLE reached after the term column.
- Column with term in lane 2 and start in lane 4 -> state stays FRAME, next frame data passes through unaltered.
- Force 2^CNT_W+3 underruns (CNT_W=4 build) -> underrun_cnt saturates at 15. Assert rrst mid-frame -> outputs return to Idle and the counter reads 0 asynchronously.

Source files
------------

// File: rtl/pcs_xgmii_pkg.sv
// Shared XGMII control characters, canned columns and the TX FIFO read-side
// state encoding used by the 10GBASE-R transmit path.
package pcs_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // Columns are packed as {txc, txd}, the same layout as the FIFO word.
    localparam logic [71:0] IDLE_COL  = {8'hFF, {8{XGMII_IDLE}}};
    localparam logic [71:0] ERROR_COL = {8'hFF, {8{XGMII_ERROR}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        ABORT = 2'd2
    } rd_state_e;

endpackage

// File: rtl/xgmii_ctrl_decode.sv
// Combinational Start/Terminate detector for one 72-bit XGMII column
// ({txc[7:0], txd[63:0]}).
module xgmii_ctrl_decode
    import pcs_xgmii_pkg::*;
#(
    parameter int LANE4_START = 1
) (
    input  logic [71:0] col,
    output logic        start,
    output logic        start_lane4,
    output logic        term
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (col[64+i] && (col[8*i +: 8] == XGMII_TERM)) begin
                term = 1'b1;
            end
        end
        start_lane4 = (LANE4_START != 0) && col[68] && (col[39:32] == XGMII_START);
        start       = (col[64] && (col[7:0] == XGMII_START)) || start_lane4;
    end

endmodule

// File: rtl/tx_fifo_rd_ctrl.sv
// Read-side controller of the TX CDC FIFO: pops columns for the 64b/66b
// encoder, fills gaps with Idle and aborts frames that underrun mid-frame.
module tx_fifo_rd_ctrl
    import pcs_xgmii_pkg::*;
#(
    parameter int DSIZE       = 72,
    parameter int CNT_W       = 16,
    parameter int LANE4_START = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             enc_ready,
    output logic [63:0]      txd,
    output logic [7:0]       txc,
    output logic             tx_valid,
    output logic             in_frame,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    rd_state_e   state, state_next;
    logic [71:0] col_next;
    logic        underrun_hit;
    logic        start, start_lane4, term;

    xgmii_ctrl_decode #(.LANE4_START(LANE4_START)) u_decode (
        .col         (rdata),
        .start       (start),
        .start_lane4 (start_lane4),
        .term        (term)
    );

    assign rinc     = enc_ready & ~rempty;
    assign in_frame = (state == FRAME);

    always_comb begin
        state_next   = state;
        col_next     = rdata;
        underrun_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (rempty) begin
                    col_next = IDLE_COL;
                end else if (start && !term) begin
                    state_next = FRAME;
                end
            end
            FRAME: begin
                if (rempty) begin
                    col_next     = ERROR_COL;
                    underrun_hit = 1'b1;
                    state_next   = ABORT;
                end else if (term) begin
                    // A Start in lane 4 behind the Terminate opens the next frame.
                    state_next = start_lane4 ? FRAME : IDLE;
                end
            end
            ABORT: begin
                col_next = IDLE_COL;
                if (!rempty && term) begin
                    state_next = start_lane4 ? FRAME : IDLE;
                end
            end
            default: begin
                col_next   = IDLE_COL;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state        <= IDLE;
            txd          <= IDLE_COL[63:0];
            txc          <= IDLE_COL[71:64];
            tx_valid     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            tx_valid <= enc_ready;
            underrun <= enc_ready & underrun_hit;
            if (enc_ready) begin
                state      <= state_next;
                {txc, txd} <= col_next;
                if (underrun_hit && (underrun_cnt != {CNT_W{1'b1}})) begin
                    underrun_cnt <= underrun_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_fifo_rd_ctrl.sv
// Self-checking bench for tx_fifo_rd_ctrl: queue-based FIFO, random frame
// traffic with gaps and encoder pauses, and a column-level reference model.
module tb_tx_fifo_rd_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_ABORT = 2;

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic             rempty = 1'b1;
    logic [71:0]      rdata = '0;
    logic             rinc;
    logic             enc_ready = 1'b0;
    logic [63:0]      txd;
    logic [7:0]       txc;
    logic             tx_valid;
    logic             in_frame;
    logic             underrun;
    logic [CNT_W-1:0] underrun_cnt;

    tx_fifo_rd_ctrl #(.DSIZE(72), .CNT_W(CNT_W), .LANE4_START(1)) dut (
        .rclk         (rclk),
        .rrst         (rrst),
        .rempty       (rempty),
        .rdata        (rdata),
        .rinc         (rinc),
        .enc_ready    (enc_ready),
        .txd          (txd),
        .txc          (txc),
        .tx_valid     (tx_valid),
        .in_frame     (in_frame),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [71:0] src[$];
    logic [71:0] fifo[$];

    int          m_mode  = M_IDLE;
    logic [71:0] m_col   = IDLE_W;
    bit          m_valid = 1'b0;
    bit          m_under = 1'b0;
    int          m_cnt   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit has_term(input logic [71:0] c);
        for (int i = 0; i < 8; i++) begin
            if (c[64+i] && c[8*i +: 8] == 8'hFD) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit has_start4(input logic [71:0] c);
        return c[68] && c[39:32] == 8'hFB;
    endfunction

    function automatic bit has_start(input logic [71:0] c);
        return (c[64] && c[7:0] == 8'hFB) || has_start4(c);
    endfunction

    function automatic logic [71:0] rand_data();
        logic [63:0] d;
        d = {$urandom, $urandom};
        return {8'h00, d};
    endfunction

    function automatic logic [71:0] start_col();
        logic [71:0] c;
        c = rand_data();
        c[7:0] = 8'hFB;
        c[64]  = 1'b1;
        return c;
    endfunction

    // Terminate in lane t; with b2b (t<4) a new Start sits in lane 4.
    function automatic logic [71:0] term_col(input int t, input bit b2b);
        logic [71:0] c;
        c = rand_data();
        for (int i = 0; i < 8; i++) begin
            if (i == t) begin
                c[8*i +: 8] = 8'hFD;
                c[64+i]     = 1'b1;
            end else if (i > t && b2b && i == 4) begin
                c[8*i +: 8] = 8'hFB;
                c[64+i]     = 1'b1;
            end else if (i > t && !(b2b && i > 4)) begin
                c[8*i +: 8] = 8'h07;
                c[64+i]     = 1'b1;
            end
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_col   = IDLE_W;
        m_valid = 1'b0;
        m_under = 1'b0;
        m_cnt   = 0;
        fifo.delete();
        src.delete();
    endtask

    // One rclk cycle: optionally move a source word into the FIFO, drive the
    // encoder handshake, predict the column and compare after the edge.
    task automatic one_cycle(input bit rdy, input int push_pct);
        bit          empty;
        logic [71:0] w;
        logic [95:0] junk;
        @(negedge rclk);
        cyc++;
        if (src.size() > 0 && $urandom_range(99) < push_pct) fifo.push_back(src.pop_front());
        empty = (fifo.size() == 0);
        junk  = {$urandom, $urandom, $urandom};
        w     = empty ? junk[71:0] : fifo[0];
        enc_ready = rdy;
        rempty    = empty;
        rdata     = w;
        #1;
        check("rinc", 72'(rinc), 72'(rdy && !empty));
        m_valid = rdy;
        m_under = 1'b0;
        if (rdy) begin
            if (m_mode == M_IDLE) begin
                m_col = empty ? IDLE_W : w;
                if (!empty && has_start(w) && !has_term(w)) m_mode = M_FRAME;
            end else if (m_mode == M_FRAME) begin
                if (empty) begin
                    m_col   = ERR_W;
                    m_under = 1'b1;
                    m_mode  = M_ABORT;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_col = w;
                    if (has_term(w)) m_mode = has_start4(w) ? M_FRAME : M_IDLE;
                end
            end else begin
                m_col = IDLE_W;
                if (!empty && has_term(w)) m_mode = has_start4(w) ? M_FRAME : M_IDLE;
            end
        end
        @(posedge rclk);
        #1;
        if (rdy && !empty) void'(fifo.pop_front());
        check("txc_txd", {txc, txd}, m_col);
        check("tx_valid", 72'(tx_valid), 72'(m_valid));
        check("underrun", 72'(underrun), 72'(m_under));
        check("underrun_cnt", 72'(underrun_cnt), 72'(m_cnt));
        check("in_frame", 72'(in_frame), 72'(m_mode == M_FRAME));
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst = 1'b1;
        model_reset();
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    initial begin : main
        int          n_in;
        int          budget;
        int          pct;
        bit          rdy;
        logic [71:0] b2b;
        logic [71:0] d0;

        // Reset state
        rempty    = 1'b1;
        enc_ready = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        check("rst_txd_txc", {txc, txd}, IDLE_W);
        check("rst_tx_valid", 72'(tx_valid), 72'(0));
        check("rst_cnt", 72'(underrun_cnt), 72'(0));
        check("rst_in_frame", 72'(in_frame), 72'(0));
        do_reset();
        repeat (10) one_cycle(1'b1, 100);
        check("idle_valid_lit", 72'(tx_valid), 72'(1));
        check("idle_col_lit", {txc, txd}, IDLE_W);

        // Clean frame: start, 6 data, terminate in lane 4
        src.push_back(start_col());
        repeat (6) src.push_back(rand_data());
        src.push_back(term_col(4, 1'b0));
        check("term_txc_lit", 72'(src[7][71:64]), 72'(8'hF0));
        n_in = 0;
        repeat (9) begin
            one_cycle(1'b1, 100);
            if (in_frame) n_in++;
        end
        check("frame_in_frame_cycles", 72'(n_in), 72'(7));

        // Underrun after 3 frame columns, then drain the remainder
        src.push_back(start_col());
        repeat (3) src.push_back(rand_data());
        repeat (4) one_cycle(1'b1, 100);
        one_cycle(1'b1, 100);
        check("err_col_lit", {txc, txd}, ERR_W);
        check("err_pulse_lit", 72'(underrun), 72'(1));
        check("err_cnt_lit", 72'(underrun_cnt), 72'(1));
        one_cycle(1'b1, 100);
        check("err_pulse_end_lit", 72'(underrun), 72'(0));
        repeat (3) src.push_back(rand_data());
        src.push_back(term_col(1, 1'b0));
        repeat (4) one_cycle(1'b1, 100);
        check("abort_idle_lit", {txc, txd}, IDLE_W);
        check("abort_done_lit", 72'(in_frame), 72'(0));

        // Back-to-back: terminate in lane 2, start in lane 4
        b2b = term_col(2, 1'b1);
        d0  = rand_data();
        check("b2b_txc_lit", 72'(b2b[71:64]), 72'(8'h1C));
        src.push_back(start_col());
        src.push_back(rand_data());
        src.push_back(b2b);
        src.push_back(d0);
        src.push_back(term_col(0, 1'b0));
        repeat (3) one_cycle(1'b1, 100);
        check("b2b_pass_lit", {txc, txd}, b2b);
        check("b2b_in_frame_lit", 72'(in_frame), 72'(1));
        one_cycle(1'b1, 100);
        check("b2b_next_data_lit", {txc, txd}, d0);
        one_cycle(1'b1, 100);
        check("b2b_end_lit", 72'(in_frame), 72'(0));

        // Random traffic with gaps, underruns and periodic encoder pauses
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) src.push_back(($urandom_range(3) == 0) ?
                {8'h01, 56'h0, 8'h9C} : IDLE_W);
            src.push_back(start_col());
            repeat ($urandom_range(0, 8)) src.push_back(rand_data());
            if ($urandom_range(3) == 0) begin
                src.push_back(term_col($urandom_range(0, 3), 1'b1));
                repeat ($urandom_range(0, 5)) src.push_back(rand_data());
            end
            src.push_back(term_col($urandom_range(0, 7), 1'b0));
            case ($urandom_range(2))
                0:       pct = 100;
                1:       pct = 85;
                default: pct = 55;
            endcase
            budget = 0;
            while ((src.size() > 0 || fifo.size() > 0) && budget < 2000) begin
                rdy = (cyc % 33 != 32) && ($urandom_range(99) < 93);
                one_cycle(rdy, pct);
                budget++;
            end
            check("drain_budget", 72'(budget < 2000), 72'(1));
        end

        // Counter saturation
        do_reset();
        for (int k = 0; k < CNT_MAX + 4; k++) begin
            src.push_back(start_col());
            one_cycle(1'b1, 100);
            one_cycle(1'b1, 100);
            src.push_back(term_col(0, 1'b0));
            one_cycle(1'b1, 100);
        end
        check("cnt_saturated_lit", 72'(underrun_cnt), 72'(15));

        // Asynchronous reset in the middle of a frame
        src.push_back(start_col());
        repeat (3) src.push_back(rand_data());
        repeat (3) one_cycle(1'b1, 100);
        check("pre_rst_in_frame_lit", 72'(in_frame), 72'(1));
        @(negedge rclk);
        #2 rrst = 1'b1;
        #1;
        check("arst_col", {txc, txd}, IDLE_W);
        check("arst_cnt", 72'(underrun_cnt), 72'(0));
        check("arst_in_frame", 72'(in_frame), 72'(0));
        check("arst_valid", 72'(tx_valid), 72'(0));
        model_reset();
        @(negedge rclk);
        rrst = 1'b0;
        repeat (4) one_cycle(1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
